t_vals_streamer: RTL and testbench

Driver side of the phi T-value interface. Holds per-interval T values (NU_VALUES words per interval) written by the segment-calculation stage, and on command emits one `input_start` pulse followed by one `input_valid` beat per interval carrying that interval's right-endpoint T values, in interval order. It sits between segment calculation and `phi` and produces exactly the start/valid/T_vals sequence `phi` consumes.

---
 rtl/formant_pkg.sv | 20 ++
 rtl/t_vals_buffer.sv | 42 ++++
 rtl/t_vals_streamer.sv | 155 +++++++++++++++
 tb/tb_t_vals_streamer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/formant_pkg.sv
// Shared constants and types for the formant / phi datapath.
// Holds default widths, the T-value streamer state encoding and an index-width helper.
package formant_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;
  localparam int DEFAULT_NU_VALUES = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } streamer_state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t_vals_buffer.sv
// Per-interval T-value storage: one word write port, one full-interval combinational read port.
// Out-of-range write indices are dropped; contents clear on reset.
module t_vals_buffer
  import formant_pkg::*;
#(
  parameter int BIT_WIDTH     = DEFAULT_BIT_WIDTH,
  parameter int NU_VALUES     = DEFAULT_NU_VALUES,
  parameter int MAX_INTERVALS = 16,
  localparam int IW = idx_width(MAX_INTERVALS),
  localparam int NW = idx_width(NU_VALUES)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [IW-1:0]                        wr_interval,
  input  logic [NW-1:0]                        wr_nu,
  input  logic [BIT_WIDTH-1:0]                 wr_data,
  input  logic [IW-1:0]                        rd_interval,
  output logic [NU_VALUES-1:0][BIT_WIDTH-1:0]  rd_data
);

  localparam logic [IW:0] INTERVAL_LIMIT = (IW+1)'(MAX_INTERVALS);
  localparam logic [NW:0] NU_LIMIT       = (NW+1)'(NU_VALUES);

  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] mem_r [MAX_INTERVALS];
  logic                                in_range_s;

  assign in_range_s = ({1'b0, wr_interval} < INTERVAL_LIMIT) && ({1'b0, wr_nu} < NU_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_INTERVALS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en && in_range_s) begin
      mem_r[wr_interval][wr_nu] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_interval];

endmodule

// File: rtl/t_vals_streamer.sv
// Driver side of the phi T-value interface: buffers per-interval T values and streams
// one start pulse followed by one valid beat per interval, in interval order.
module t_vals_streamer
  import formant_pkg::*;
#(
  parameter int BIT_WIDTH     = DEFAULT_BIT_WIDTH,
  parameter int NU_VALUES     = DEFAULT_NU_VALUES,
  parameter int MAX_INTERVALS = 16,
  parameter int BEAT_SPACING  = 1,
  localparam int IW = idx_width(MAX_INTERVALS),
  localparam int NW = idx_width(NU_VALUES),
  localparam int CW = IW + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_en_in,
  input  logic [IW-1:0]         wr_interval_in,
  input  logic [NW-1:0]         wr_nu_in,
  input  logic [BIT_WIDTH-1:0]  wr_data_in,
  input  logic                  go_in,
  input  logic [CW-1:0]         num_intervals_in,
  input  logic                  abort_in,
  output logic [BIT_WIDTH-1:0]  T_vals [NU_VALUES],
  output logic                  input_start,
  output logic                  input_valid,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int              SW             = idx_width(BEAT_SPACING);
  localparam logic [CW-1:0]   MAX_N          = CW'(MAX_INTERVALS);
  localparam logic [SW-1:0]   SPACING_RELOAD = SW'(BEAT_SPACING - 1);

  streamer_state_t                     state_r, state_s;
  logic [CW-1:0]                       idx_r, idx_s;
  logic [CW-1:0]                       n_r, n_s;
  logic [SW-1:0]                       cnt_r, cnt_s;
  logic                                start_s, valid_s, done_s, busy_s;
  logic                                buf_wr_en_s;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] rd_data_s;

  // Buffer is frozen while a stream is in flight.
  assign buf_wr_en_s = wr_en_in && (state_r == ST_IDLE);

  t_vals_buffer #(
    .BIT_WIDTH     (BIT_WIDTH),
    .NU_VALUES     (NU_VALUES),
    .MAX_INTERVALS (MAX_INTERVALS)
  ) u_buffer (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .wr_en       (buf_wr_en_s),
    .wr_interval (wr_interval_in),
    .wr_nu       (wr_nu_in),
    .wr_data     (wr_data_in),
    .rd_interval (idx_r[IW-1:0]),
    .rd_data     (rd_data_s)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      n_r     <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      n_r     <= n_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic also decides what the output registers show next cycle,
  // so the START cycle already schedules beat 0 for the following cycle.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    n_s     = n_r;
    cnt_s   = cnt_r;
    start_s = 1'b0;
    valid_s = 1'b0;
    done_s  = 1'b0;
    if (abort_in && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_in) begin
            if (num_intervals_in == '0) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else begin
              state_s = ST_START;
              start_s = 1'b1;
              n_s     = (num_intervals_in > MAX_N) ? MAX_N : num_intervals_in;
              idx_s   = '0;
              cnt_s   = '0;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_START: begin
          state_s = ST_STREAM;
          valid_s = 1'b1;
          idx_s   = idx_r + CW'(1);
          cnt_s   = SPACING_RELOAD;
        end
        ST_STREAM: begin
          if (idx_r == n_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else if (cnt_r == '0) begin
            valid_s = 1'b1;
            idx_s   = idx_r + CW'(1);
            cnt_s   = SPACING_RELOAD;
          end else begin
            cnt_s   = cnt_r - SW'(1);
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      input_start <= 1'b0;
      input_valid <= 1'b0;
      done_out    <= 1'b0;
      busy_out    <= 1'b0;
      for (int j = 0; j < NU_VALUES; j++) begin
        T_vals[j] <= '0;
      end
    end else begin
      input_start <= start_s;
      input_valid <= valid_s;
      done_out    <= done_s;
      busy_out    <= busy_s;
      if (valid_s) begin
        for (int j = 0; j < NU_VALUES; j++) begin
          T_vals[j] <= rd_data_s[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_t_vals_streamer.sv
// Self-checking bench: two streamers (beat spacing 1 and 3) share all inputs and are checked
// cycle by cycle against timing formulas and a word-array model of the buffer.
module tb_t_vals_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_interval = 4'd0;
  logic [1:0]  wr_nu = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        go = 1'b0;
  logic [4:0]  num = 5'd0;
  logic        abort = 1'b0;

  logic [31:0] t1 [3];
  logic [31:0] t3 [3];
  logic        s1_start, s1_valid, s1_busy, s1_done;
  logic        s3_start, s3_valid, s3_busy, s3_done;

  logic [31:0] mdl   [16][3];
  logic [31:0] exp_t [2][3];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  t_vals_streamer #(.BIT_WIDTH(32), .NU_VALUES(3), .MAX_INTERVALS(16), .BEAT_SPACING(1)) u_s1 (
    .clk_in(clk), .rst_in(rst), .wr_en_in(wr_en), .wr_interval_in(wr_interval),
    .wr_nu_in(wr_nu), .wr_data_in(wr_data), .go_in(go), .num_intervals_in(num),
    .abort_in(abort), .T_vals(t1), .input_start(s1_start), .input_valid(s1_valid),
    .busy_out(s1_busy), .done_out(s1_done)
  );

  t_vals_streamer #(.BIT_WIDTH(32), .NU_VALUES(3), .MAX_INTERVALS(16), .BEAT_SPACING(3)) u_s3 (
    .clk_in(clk), .rst_in(rst), .wr_en_in(wr_en), .wr_interval_in(wr_interval),
    .wr_nu_in(wr_nu), .wr_data_in(wr_data), .go_in(go), .num_intervals_in(num),
    .abort_in(abort), .T_vals(t3), .input_start(s3_start), .input_valid(s3_valid),
    .busy_out(s3_busy), .done_out(s3_done)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Checks both DUTs against expected control bits {start,valid,done,busy} and held T values.
  task automatic chk_both(input string tag, input logic [3:0] e1, input logic [3:0] e3);
    chk({tag, " s1 ctl"}, 96'({s1_start, s1_valid, s1_done, s1_busy}), 96'(e1));
    chk({tag, " s3 ctl"}, 96'({s3_start, s3_valid, s3_done, s3_busy}), 96'(e3));
    chk({tag, " s1 T"}, {t1[0], t1[1], t1[2]}, {exp_t[0][0], exp_t[0][1], exp_t[0][2]});
    chk({tag, " s3 T"}, {t3[0], t3[1], t3[2]}, {exp_t[1][0], exp_t[1][1], exp_t[1][2]});
  endtask

  task automatic clear_model();
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 3; j++) mdl[k][j] = 32'd0;
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < 3; j++) exp_t[d][j] = 32'd0;
  endtask

  // Called right after a negedge; returns right after the next negedge.
  task automatic wr(input int k, input int j, input logic [31:0] v);
    wr_en = 1'b1;
    wr_interval = 4'(k);
    wr_nu = 2'(j);
    wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    if (k < 16 && j < 3) mdl[k][j] = v;
  endtask

  // Issue go with n, optionally pulse abort during cycle ab and attempt a write during cycle wc.
  // Cycle c is the period after the c-th rising edge following the go edge.
  task automatic run_stream(input int n, input int ab, input int wc);
    int   sp [2];
    int   dc [2];
    int   neff;
    int   len;
    logic live, e_start, e_valid, e_done, e_busy;
    logic [3:0] e_ctl [2];
    sp[0] = 1;
    sp[1] = 3;
    neff = (n > 16) ? 16 : n;
    len = 0;
    for (int d = 0; d < 2; d++) begin
      dc[d] = (neff == 0) ? 1 : 2 + (neff - 1) * sp[d] + 1;
      if (dc[d] + 3 > len) len = dc[d] + 3;
    end
    go = 1'b1;
    num = 5'(n);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      go = 1'b0;
      abort = 1'b0;
      wr_en = 1'b0;
      live = (ab == 0) || (c <= ab);
      for (int d = 0; d < 2; d++) begin
        e_start = live && (neff > 0) && (c == 1);
        e_valid = live && (neff > 0) && (c >= 2) && (((c - 2) % sp[d]) == 0) && (((c - 2) / sp[d]) < neff);
        e_done  = live && (c == dc[d]);
        e_busy  = live && (c <= dc[d]);
        if (e_valid)
          for (int j = 0; j < 3; j++) exp_t[d][j] = mdl[(c - 2) / sp[d]][j];
        e_ctl[d] = {e_start, e_valid, e_done, e_busy};
      end
      chk_both($sformatf("n%0d ab%0d c%0d", n, ab, c), e_ctl[0], e_ctl[1]);
      abort = (ab != 0) && (c == ab);
      if (c == wc) begin
        wr_en = 1'b1;
        wr_interval = 4'd15;
        wr_nu = 2'd1;
        wr_data = $urandom;
      end
    end
    abort = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    chk_both("reset held", 4'b0000, 4'b0000);
    rst = 1'b1;
    @(negedge clk);
    chk_both("reset released", 4'b0000, 4'b0000);

    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) wr(k, j, 32'(100 * k + j));
    wr(0, 3, 32'hDEAD_BEEF);
    run_stream(4, 0, 0);
    run_stream(2, 0, 0);
    run_stream(0, 0, 0);

    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 3; j++) wr(k, j, $urandom);
    run_stream(20, 0, 3);
    run_stream(5, 3, 0);
    run_stream(5, 0, 0);
    for (int r = 0; r < 3; r++) begin
      wr($urandom_range(0, 15), $urandom_range(0, 2), $urandom);
      run_stream($urandom_range(1, 16), $urandom_range(0, 8), 0);
    end
    run_stream(1, 0, 0);

    go = 1'b1;
    num = 5'd16;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    clear_model();
    chk_both("async reset mid-stream", 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_both($sformatf("post-reset idle %0d", c), 4'b0000, 4'b0000);
    end
    run_stream(3, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
